// File: rtl/interleave_pkg.sv
// rtl/interleave_pkg.sv - modulation decode and OFDM interleaver geometry, shared with the RX deinterleaver
package interleave_pkg;

  localparam int CBPS_W = 9;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_16QAM = 2'd2,
    MOD_64QAM = 2'd3
  } mod_t;

  typedef struct packed {
    logic ht;
    mod_t mod;
  } sym_cfg_t;

  function automatic mod_t decode_mod(input logic [7:0] rate);
    case ({rate[7], rate[3:0]})
      5'b01011, 5'b01111, 5'b10000:           decode_mod = MOD_BPSK;
      5'b01010, 5'b01110, 5'b10001, 5'b10010: decode_mod = MOD_QPSK;
      5'b01001, 5'b01101, 5'b10011, 5'b10100: decode_mod = MOD_16QAM;
      5'b01000, 5'b01100, 5'b10101, 5'b10110,
      5'b10111:                               decode_mod = MOD_64QAM;
      default:                                decode_mod = MOD_BPSK;
    endcase
  endfunction

  function automatic logic [2:0] n_bpsc(input mod_t m);
    case (m)
      MOD_QPSK:  n_bpsc = 3'd2;
      MOD_16QAM: n_bpsc = 3'd4;
      MOD_64QAM: n_bpsc = 3'd6;
      default:   n_bpsc = 3'd1;
    endcase
  endfunction

  function automatic logic [4:0] n_col(input logic ht);
    n_col = ht ? 5'd13 : 5'd16;
  endfunction

  function automatic logic [4:0] n_row(input logic ht, input mod_t m);
    case (m)
      MOD_QPSK:  n_row = ht ? 5'd8  : 5'd6;
      MOD_16QAM: n_row = ht ? 5'd16 : 5'd12;
      MOD_64QAM: n_row = ht ? 5'd24 : 5'd18;
      default:   n_row = ht ? 5'd4  : 5'd3;
    endcase
  endfunction

  function automatic logic [CBPS_W-1:0] n_cbps(input logic ht, input mod_t m);
    case (m)
      MOD_QPSK:  n_cbps = ht ? 9'd104 : 9'd96;
      MOD_16QAM: n_cbps = ht ? 9'd208 : 9'd192;
      MOD_64QAM: n_cbps = ht ? 9'd312 : 9'd288;
      default:   n_cbps = ht ? 9'd52  : 9'd48;
    endcase
  endfunction

  // s = max(N_BPSC/2, 1)
  function automatic logic [1:0] n_s(input mod_t m);
    case (m)
      MOD_16QAM: n_s = 2'd2;
      MOD_64QAM: n_s = 2'd3;
      default:   n_s = 2'd1;
    endcase
  endfunction

  // 4 == 1 (mod 3), so summing base-4 digits preserves the residue
  function automatic logic [1:0] mod3(input logic [11:0] v);
    logic [4:0] acc;
    acc = '0;
    for (int d = 0; d < 6; d++) acc = acc + {3'b000, v[2*d +: 2]};
    for (int n = 0; n < 6; n++) if (acc >= 5'd3) acc = acc - 5'd3;
    return acc[1:0];
  endfunction

endpackage

// File: rtl/interleave_if.sv
// rtl/interleave_if.sv - coded-bit input and subcarrier-group output handshake bundle
interface interleave_if;
  logic       enable;
  logic [7:0] rate;
  logic       in_bit;
  logic       input_strobe;
  logic       input_ready;
  logic       out_ready;
  logic [5:0] out_bits;
  logic       output_strobe;
  logic       symbol_done;

  modport master (
    output enable, rate, in_bit, input_strobe, out_ready,
    input  input_ready, out_bits, output_strobe, symbol_done
  );

  modport slave (
    input  enable, rate, in_bit, input_strobe, out_ready,
    output input_ready, out_bits, output_strobe, symbol_done
  );
endinterface

// File: rtl/interleave_addr.sv
// rtl/interleave_addr.sv - combinational (col,row) -> permuted bit address j
module interleave_addr
  import interleave_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic [3:0]        col,
  input  logic [4:0]        row,
  input  logic [4:0]        n_row,
  input  logic [1:0]        s,
  input  logic [ADDR_W-1:0] n_cbps,
  output logic [ADDR_W-1:0] j
);

  logic [11:0] i;
  logic [11:0] t;
  logic [1:0]  i_mod;
  logic [1:0]  t_mod;

  always_comb begin
    i     = 12'(n_row) * 12'(col) + 12'(row);
    t     = i + 12'(n_cbps) - 12'(col);
    i_mod = '0;
    t_mod = '0;
    case (s)
      2'd2: begin
        i_mod = {1'b0, i[0]};
        t_mod = {1'b0, t[0]};
      end
      2'd3: begin
        i_mod = mod3(i);
        t_mod = mod3(t);
      end
      default: ;
    endcase
    j = ADDR_W'(i - 12'(i_mod) + 12'(t_mod));
  end

endmodule

// File: rtl/interleave.sv
// rtl/interleave.sv - ping-pong OFDM bit interleaver, one symbol per bank
module interleave
  import interleave_pkg::*;
#(
  parameter int MAX_CBPS = 312,
  parameter int ADDR_W   = 9
) (
  input  logic  clock,
  input  logic  reset,
  interleave_if.slave bus
);

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;

  logic [MAX_CBPS-1:0] bank [2];
  sym_cfg_t            bank_cfg [2];
  logic [1:0]          full;
  logic                wr;
  logic                rd;
  logic [ADDR_W-1:0]   k;
  logic [3:0]          col;
  logic [4:0]          row;
  logic [0:0]          rstate;
  sym_cfg_t            rd_cfg;
  logic [ADDR_W-1:0]   a;
  logic [5:0]          out_bits_q;
  logic                output_strobe_q;
  logic                symbol_done_q;

  sym_cfg_t            live_cfg;
  sym_cfg_t            wr_cfg;
  logic [4:0]          w_ncol;
  logic [4:0]          w_nrow;
  logic [ADDR_W-1:0]   w_ncbps;
  logic [1:0]          w_s;
  logic [ADDR_W-1:0]   j;
  logic                accept;

  logic [2:0]          r_bpsc;
  logic [ADDR_W-1:0]   r_ncbps;
  logic [ADDR_W-1:0]   a_next;
  logic [ADDR_W-1:0]   idx;
  logic [5:0]          group;

  // The first bit of a symbol uses the live rate; later bits use the rate latched with the bank.
  always_comb begin
    live_cfg.ht  = bus.rate[7];
    live_cfg.mod = decode_mod(bus.rate);
    wr_cfg       = (k == '0) ? live_cfg : bank_cfg[wr];
    w_ncol       = n_col(wr_cfg.ht);
    w_nrow       = n_row(wr_cfg.ht, wr_cfg.mod);
    w_ncbps      = ADDR_W'(n_cbps(wr_cfg.ht, wr_cfg.mod));
    w_s          = n_s(wr_cfg.mod);
  end

  assign accept          = bus.enable && bus.input_strobe && !full[wr];
  assign bus.input_ready = !full[wr];

  interleave_addr #(.ADDR_W(ADDR_W)) u_addr (
    .col    (col),
    .row    (row),
    .n_row  (w_nrow),
    .s      (w_s),
    .n_cbps (w_ncbps),
    .j      (j)
  );

  always_comb begin
    r_bpsc  = n_bpsc(rd_cfg.mod);
    r_ncbps = ADDR_W'(n_cbps(rd_cfg.ht, rd_cfg.mod));
    a_next  = a + ADDR_W'(r_bpsc);
    group   = '0;
    idx     = '0;
    for (int b = 0; b < 6; b++) begin
      idx = a + ADDR_W'(b);
      if (b < int'(r_bpsc) && idx < ADDR_W'(MAX_CBPS)) group[b] = bank[rd][idx];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && accept) bank[wr][j] <= bus.in_bit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full            <= '0;
      wr              <= 1'b0;
      rd              <= 1'b0;
      k               <= '0;
      col             <= '0;
      row             <= '0;
      bank_cfg[0]     <= '0;
      bank_cfg[1]     <= '0;
      rstate          <= R_IDLE;
      rd_cfg          <= '0;
      a               <= '0;
      out_bits_q      <= '0;
      output_strobe_q <= 1'b0;
      symbol_done_q   <= 1'b0;
    end else if (bus.enable) begin
      output_strobe_q <= 1'b0;
      symbol_done_q   <= 1'b0;
      if (accept) begin
        if (k == '0) bank_cfg[wr] <= live_cfg;
        if (k == w_ncbps - ADDR_W'(1)) begin
          full[wr] <= 1'b1;
          wr       <= ~wr;
          k        <= '0;
          col      <= '0;
          row      <= '0;
        end else begin
          k <= k + ADDR_W'(1);
          if ({1'b0, col} == w_ncol - 5'd1) begin
            col <= '0;
            row <= row + 5'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
      end
      // Reader updates come last so a clear of full[rd] wins over any same-cycle set.
      case (rstate)
        R_IDLE: begin
          if (full[rd]) begin
            rd_cfg <= bank_cfg[rd];
            a      <= '0;
            rstate <= R_DRAIN;
          end
        end
        default: begin
          if (bus.out_ready) begin
            out_bits_q      <= group;
            output_strobe_q <= 1'b1;
            a               <= a_next;
            if (a_next == r_ncbps) begin
              symbol_done_q <= 1'b1;
              full[rd]      <= 1'b0;
              rd            <= ~rd;
              rstate        <= R_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.out_bits      = out_bits_q;
  assign bus.output_strobe = output_strobe_q;
  assign bus.symbol_done   = symbol_done_q;

endmodule

// File: doc/interleave.md
Name: interleave

Overview:
- TX-side OFDM bit interleaver for legacy 802.11a/g (48 data subcarriers) and HT (52 data subcarriers).
- Sits between the convolutional encoder/puncturer and the constellation mapper.
- Collects one OFDM symbol of coded bits (N_CBPS) and writes each bit to its permuted address using the standard two-step interleaver permutation.
- Drains the symbol as one N_BPSC-bit group per strobe, one group per data subcarrier.
- Ping-pong buffered, so a new symbol can be filled while the previous one is drained.

Parameters:
- MAX_CBPS, 312, largest N_CBPS supported (HT 64-QAM); sets bank size.
- ADDR_W, 9, width of bit address within a bank.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  clock enable; when low, all state holds
- rate  in  8  rate[7]=ht, rate[3:0]=rate/MCS code, same encoding as the RX path
- in_bit  in  1  coded bit
- input_strobe  in  1  in_bit valid; accepted only when input_ready=1
- input_ready  out  1  high while a bank is available for filling
- out_ready  in  1  mapper accepts a group this cycle
- out_bits  out  6  subcarrier bit group; bit 0 is the first bit of the subcarrier; unused MSBs are 0
- output_strobe  out  1  out_bits valid
- symbol_done  out  1  one-cycle pulse with the last group of a symbol

Behaviour:
- Reset values: input_ready=1, out_bits=0, output_strobe=0, symbol_done=0. Both banks empty; write and read bank pointers = 0; all counters = 0.
- Modulation is decoded from {rate[7], rate[3:0]}:
  - BPSK: 01011, 01111, 10000 → N_BPSC=1
  - QPSK: 01010, 01110, 10001, 10010 → N_BPSC=2
  - 16-QAM: 01001, 01101, 10011, 10100 → N_BPSC=4
  - 64-QAM: 01000, 01100, 10101, 10110, 10111 → N_BPSC=6
  - Any other code is treated as BPSK.
- Geometry:
  - N_COL = 16 (legacy) or 13 (HT).
  - N_ROW = 3·N_BPSC (legacy) or 4·N_BPSC (HT).
  - N_CBPS = N_COL·N_ROW.
  - s = max(N_BPSC/2, 1).
- Rate is latched on the first accepted bit of each symbol. The latched rate is carried with that bank to the read side; rate changes mid-symbol are ignored.
- Write permutation, with no dividers:
  - Maintain col = k mod N_COL and row = floor(k/N_COL) as wrapping counters.
  - i = N_ROW·col + row.
  - j = s·floor(i/s) + ((i + N_CBPS − col) mod s), computed with small constant-range logic since s ∈ {1,2,3}.
  - On each accepted strobe, bank[wr][j] ← in_bit.
- Write FSM:
  - W_FILL: count k. When k = N_CBPS−1 is accepted, mark bank full, toggle the write bank, clear k/col/row.
  - input_ready = !full[write bank].
- Read FSM:
  - R_IDLE: on full[rd], latch that bank's rate and go to R_DRAIN.
  - R_DRAIN: when out_ready, present bank[rd][a +: N_BPSC] registered and advance a += N_BPSC.
  - After group N_CBPS/N_BPSC−1: pulse symbol_done, clear full[rd], toggle rd, return to R_IDLE.
  - output_strobe is high only on cycles where a group is presented with out_ready=1.
- Latency: first output_strobe is 2 cycles after the last bit of a symbol is accepted (full flag, then registered read), given out_ready=1.
- Boundary conditions:
  - The write side may fill one bank while the other drains.
  - If both banks are full, input_ready=0 and strobes are ignored (no overwrite).
  - A bank cleared by the reader and re-targeted by the writer in the same cycle is legal: the clear takes priority and input_ready rises next cycle.
  - Reset mid-symbol discards all partial and full banks.
  - No partial-symbol flush exists; the upstream pads to whole symbols.

Decomposition:
- Shared package: modulation-type constants, and N_BPSC / N_COL / N_ROW / N_CBPS derivation functions, shared with the RX deinterleaver.
- One natural sub-module, interleave_addr: combinational k-counters → j permutation (col, row, N_ROW, s, N_CBPS in; j out).

Test Plan:
- Legacy BPSK (rate=8'h0B), single 1 at k=1 of 48 → only output group 3 is 1; symbol_done on group 47.
- Legacy 16-QAM (8'h09), single 1 at k=1 → j=13: group 3 out_bits=4'b0010; 48 groups total.
- Legacy 64-QAM (8'h08), single 1 at k=2 → j=37: group 6 out_bits=6'b000010; walking-one sweep over k=0..287 matches the golden model.
- HT MCS0 (8'h80), single 1 at k=13 → j=1; 52 groups; then HT 64-QAM (8'h87) full sweep over 312 bits matches the golden model.
- Back-to-back symbols with out_ready=0 → input_ready drops after 2 symbols; releasing out_ready restores it; no data loss.
- Reset asserted mid-fill and mid-drain → no output_strobe after reset; next symbol correct.
